// File: rtl/aud_pkg.sv
// aud_pkg: shared types and constants for the audio record/play sequencer.
`default_nettype none

package aud_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_STOP  = 3'd2,
    S_DSP   = 3'd3,
    S_WAIT  = 3'd4,
    S_PAUSE = 3'd5
  } aud_seq_state_e;

  localparam logic M_PLAY = 1'b0;
  localparam logic M_RECD = 1'b1;

  localparam int DEF_SPD_UNITY = 7;
  localparam int DEF_SPD_MAX   = 14;

endpackage

`default_nettype wire

// File: rtl/aud_speed_ctrl.sv
// aud_speed_ctrl: saturating up/down speed code, pinned to unity while recording.
`default_nettype none

module aud_speed_ctrl
  import aud_pkg::*;
#(
  parameter int SPD_W     = 4,
  parameter int SPD_MAX   = DEF_SPD_MAX,
  parameter int SPD_UNITY = DEF_SPD_UNITY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_fast,
  input  logic             key_slow,
  input  logic             mode,
  output logic [SPD_W-1:0] speed
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed <= SPD_W'(SPD_UNITY);
    end else if (mode == M_RECD) begin
      speed <= SPD_W'(SPD_UNITY);
    end else if (key_fast && !key_slow && (speed < SPD_W'(SPD_MAX))) begin
      speed <= speed + SPD_W'(1);
    end else if (key_slow && !key_fast && (speed != '0)) begin
      speed <= speed - SPD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/aud_seq_ctrl.sv
// aud_seq_ctrl: codec-init, start/pause/stop and per-channel DSP->player/recorder sequencer.
// Define AUD_SEQ_LOOP_EN to make a play-mode length limit restart playback instead of stopping.
`default_nettype none

module aud_seq_ctrl
  import aud_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 20,
  parameter int SPD_W     = 4,
  parameter int SPD_MAX   = DEF_SPD_MAX,
  parameter int SPD_UNITY = DEF_SPD_UNITY,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic              i_interpol,
  input  logic              i_key_start,
  input  logic              i_key_stop,
  input  logic              i_key_fast,
  input  logic              i_key_slow,
  output logic              o_init_start,
  input  logic              i_init_fin,
  output logic              o_dsp_clear,
  output logic              o_dsp_start,
  input  logic              i_dsp_fin,
  output logic              o_io_start,
  input  logic              i_io_fin,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [CH_W-1:0]   o_chan,
  output logic              o_mode,
  output logic              o_interpol,
  output logic [SPD_W-1:0]  o_speed,
  output logic [ADDR_W-1:0] o_rec_end,
  output logic              o_running,
  output logic              o_paused
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  aud_seq_state_e state, next_state;
  logic [CH_W-1:0] chan_nxt;
  logic            pend_pause, pend_pause_nxt;
  logic            pend_stop, pend_stop_nxt;
  logic            loop_clr;
  logic            limit_hit;

  // Length limit: recorder fills SRAM, or playback reaches the recorded end.
  assign limit_hit = ((o_mode == M_RECD) && (&i_addr)) ||
                     ((o_mode == M_PLAY) && (i_addr >= o_rec_end));

  always_comb begin
    next_state     = state;
    chan_nxt       = o_chan;
    loop_clr       = 1'b0;
    pend_pause_nxt = 1'b0;
    pend_stop_nxt  = 1'b0;
    if ((state == S_DSP) || (state == S_WAIT)) begin
      pend_pause_nxt = pend_pause | i_key_start;
      pend_stop_nxt  = pend_stop | i_key_stop;
    end
    case (state)
      S_IDLE: next_state = S_INIT;
      S_INIT: if (i_init_fin) next_state = S_STOP;
      S_STOP: begin
        if (i_key_start && !i_key_stop) begin
          chan_nxt   = '0;
          next_state = S_DSP;
        end
      end
      S_DSP: if (i_dsp_fin) next_state = S_WAIT;
      S_WAIT: begin
        if (i_io_fin) begin
          if (o_chan < LAST_CH) begin
            chan_nxt   = o_chan + CH_W'(1);
            next_state = S_DSP;
          end else begin
            // Frame end: requests are consumed here whatever the outcome.
            pend_pause_nxt = 1'b0;
            pend_stop_nxt  = 1'b0;
            if (pend_stop || i_key_stop) begin
              next_state = S_STOP;
            end else if (limit_hit) begin
`ifdef AUD_SEQ_LOOP_EN
              if (o_mode == M_PLAY) begin
                loop_clr   = 1'b1;
                chan_nxt   = '0;
                next_state = S_DSP;
              end else begin
                next_state = S_STOP;
              end
`else
              next_state = S_STOP;
`endif
            end else if (pend_pause || i_key_start) begin
              next_state = S_PAUSE;
            end else begin
              chan_nxt   = '0;
              next_state = S_DSP;
            end
          end
        end
      end
      S_PAUSE: begin
        if (i_key_stop) begin
          next_state = S_STOP;
        end else if (i_key_start) begin
          chan_nxt   = '0;
          next_state = S_DSP;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_chan       <= '0;
      pend_pause   <= 1'b0;
      pend_stop    <= 1'b0;
      o_init_start <= 1'b0;
      o_dsp_clear  <= 1'b0;
      o_dsp_start  <= 1'b0;
      o_io_start   <= 1'b0;
      o_mode       <= M_PLAY;
      o_interpol   <= 1'b0;
      o_rec_end    <= '1;
      o_running    <= 1'b0;
      o_paused     <= 1'b0;
    end else begin
      state        <= next_state;
      o_chan       <= chan_nxt;
      pend_pause   <= pend_pause_nxt;
      pend_stop    <= pend_stop_nxt;
      o_init_start <= (next_state == S_INIT) && (state != S_INIT);
      o_dsp_start  <= (next_state == S_DSP) && (state != S_DSP);
      o_io_start   <= (next_state == S_WAIT) && (state != S_WAIT);
      o_dsp_clear  <= (next_state == S_STOP) || loop_clr;
      o_running    <= (next_state == S_DSP) || (next_state == S_WAIT) ||
                      (next_state == S_PAUSE);
      o_paused     <= (next_state == S_PAUSE);
      if (state == S_STOP) begin
        o_mode     <= i_mode;
        o_interpol <= i_interpol;
      end
      if ((next_state == S_STOP) && ((state == S_WAIT) || (state == S_PAUSE)) &&
          (o_mode == M_RECD)) begin
        o_rec_end <= i_addr;
      end
    end
  end

  aud_speed_ctrl #(
    .SPD_W    (SPD_W),
    .SPD_MAX  (SPD_MAX),
    .SPD_UNITY(SPD_UNITY)
  ) u_speed (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .key_fast(i_key_fast),
    .key_slow(i_key_slow),
    .mode    (o_mode),
    .speed   (o_speed)
  );

endmodule

`default_nettype wire

// File: tb/tb_aud_seq_ctrl.sv
// tb_aud_seq_ctrl: directed self-checking bench for aud_seq_ctrl (N_CH=2, ADDR_W=20).
`default_nettype none

module tb_aud_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0, interpol = 1'b0;
  logic        key_start = 1'b0, key_stop = 1'b0, key_fast = 1'b0, key_slow = 1'b0;
  logic        init_start, init_fin = 1'b0;
  logic        dsp_clear, dsp_start, dsp_fin = 1'b0;
  logic        io_start, io_fin = 1'b0;
  logic [19:0] addr = '0;
  logic [0:0]  chan;
  logic        mode_q, interpol_q;
  logic [3:0]  speed;
  logic [19:0] rec_end;
  logic        running, paused;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aud_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode),
    .i_interpol  (interpol),
    .i_key_start (key_start),
    .i_key_stop  (key_stop),
    .i_key_fast  (key_fast),
    .i_key_slow  (key_slow),
    .o_init_start(init_start),
    .i_init_fin  (init_fin),
    .o_dsp_clear (dsp_clear),
    .o_dsp_start (dsp_start),
    .i_dsp_fin   (dsp_fin),
    .o_io_start  (io_start),
    .i_io_fin    (io_fin),
    .i_addr      (addr),
    .o_chan      (chan),
    .o_mode      (mode_q),
    .o_interpol  (interpol_q),
    .o_speed     (speed),
    .o_rec_end   (rec_end),
    .o_running   (running),
    .o_paused    (paused)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One channel: expects to sit on DSP entry; optional keys ride on the dsp_fin cycle.
  task automatic do_chan(input int ch, input logic ks, input logic kp);
    check("dsp_start", dsp_start, 1);
    check("chan", chan, ch);
    dsp_fin = 1'b1; key_stop = ks; key_start = kp;
    tick();
    dsp_fin = 1'b0; key_stop = 1'b0; key_start = 1'b0;
    check("io_start", io_start, 1);
    check("dsp_start_low", dsp_start, 0);
    io_fin = 1'b1;
    tick();
    io_fin = 1'b0;
  endtask

  task automatic press_start();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst_running", running, 0);
    check("rst_init_start", init_start, 0);
    check("rst_dsp_clear", dsp_clear, 0);
    check("rst_speed", speed, 7);
    check("rst_rec_end", rec_end, 20'hFFFFF);
    check("rst_mode", mode_q, 0);
    rst_n = 1'b1;
    tick();
    check("init_start_c1", init_start, 1);
    tick();
    check("init_start_1cyc", init_start, 0);
    check("in_init_no_clear", dsp_clear, 0);
    tick(); tick(); tick();
    init_fin = 1'b1;
    tick();
    init_fin = 1'b0;
    check("stop_dsp_clear", dsp_clear, 1);
    check("stop_running", running, 0);

    // Record until SRAM full
    mode = 1'b1; interpol = 1'b1; addr = 20'hFFFFF;
    tick(); tick();
    check("rec_mode", mode_q, 1);
    check("rec_interpol", interpol_q, 1);
    check("rec_speed", speed, 7);
    press_start();
    check("rec_running", running, 1);
    check("rec_clear_low", dsp_clear, 0);
    do_chan(0, 0, 0);
    do_chan(1, 0, 0);
    check("full_stop", dsp_clear, 1);
    check("full_stop_run", running, 0);
    check("full_rec_end", rec_end, 20'hFFFFF);

    // Record stopped by key at 0x100
    addr = 20'h00100;
    press_start();
    do_chan(0, 1, 0);
    check("pend_stop_chan1", running, 1);
    do_chan(1, 0, 0);
    check("keystop_stop", dsp_clear, 1);
    check("keystop_rec_end", rec_end, 20'h00100);

    // Play below limit, then reach it
    mode = 1'b0; interpol = 1'b0; addr = 20'h000FF;
    tick();
    check("play_mode", mode_q, 0);
    press_start();
    do_chan(0, 0, 0);
    do_chan(1, 0, 0);
    check("play_wrap_run", running, 1);
    addr = 20'h00100;
    do_chan(0, 0, 0);
    do_chan(1, 0, 0);
    check("limit_clear", dsp_clear, 1);
    check("rec_end_kept", rec_end, 20'h00100);
`ifdef AUD_SEQ_LOOP_EN
    check("loop_run", running, 1);
    check("loop_dsp_start", dsp_start, 1);
    check("loop_chan", chan, 0);
    addr = 20'h0;
    do_chan(0, 1, 0);
    check("loop_clear_1cyc", dsp_clear, 0);
    do_chan(1, 0, 0);
    check("loop_exit_clear", dsp_clear, 1);
`else
    check("limit_run", running, 0);
    check("limit_no_dsp", dsp_start, 0);
`endif

    // Pause mid-frame, resume, ignore stray dsp_fin, then start+stop in PAUSE
    addr = 20'h0;
    press_start();
    do_chan(0, 0, 1);
    check("pause_pend_chan1", paused, 0);
    do_chan(1, 0, 0);
    check("pause_paused", paused, 1);
    check("pause_running", running, 1);
    check("pause_no_start", dsp_start, 0);
    press_start();
    check("resume_start", dsp_start, 1);
    check("resume_chan", chan, 0);
    check("resume_unpaused", paused, 0);
    dsp_fin = 1'b1; tick(); dsp_fin = 1'b0;
    check("wait_io_start", io_start, 1);
    dsp_fin = 1'b1; tick(); dsp_fin = 1'b0;
    check("stray_fin_io", io_start, 0);
    check("stray_fin_dsp", dsp_start, 0);
    check("stray_fin_run", running, 1);
    io_fin = 1'b1; tick(); io_fin = 1'b0;
    do_chan(1, 0, 1);
    check("pause2", paused, 1);
    key_start = 1'b1; key_stop = 1'b1;
    tick();
    key_start = 1'b0; key_stop = 1'b0;
    check("startstop_clear", dsp_clear, 1);
    check("startstop_run", running, 0);
    check("startstop_paused", paused, 0);

    // Speed control (play mode)
    key_fast = 1'b1; tick(); key_fast = 1'b0;
    check("speed_up1", speed, 8);
    for (int i = 1; i < 10; i++) begin
      key_fast = 1'b1; tick(); key_fast = 1'b0;
    end
    check("speed_max", speed, 14);
    for (int i = 0; i < 20; i++) begin
      key_slow = 1'b1; tick(); key_slow = 1'b0;
    end
    check("speed_min", speed, 0);
    key_fast = 1'b1; tick(); key_fast = 1'b0;
    check("speed_one", speed, 1);
    key_fast = 1'b1; key_slow = 1'b1; tick(); key_fast = 1'b0; key_slow = 1'b0;
    check("speed_both", speed, 1);
    mode = 1'b1;
    tick(); tick();
    check("speed_rec_force", speed, 7);
    key_slow = 1'b1; tick(); key_slow = 1'b0;
    check("speed_rec_ignore", speed, 7);

    // Reset mid-frame
    mode = 1'b0;
    tick();
    press_start();
    dsp_fin = 1'b1; tick(); dsp_fin = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_run", running, 0);
    check("midrst_io", io_start, 0);
    check("midrst_speed", speed, 7);
    check("midrst_rec_end", rec_end, 20'hFFFFF);
    tick();
    check("midrst_no_init", init_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
